// File: rtl/pov_text_scroller_if.sv
// Host write port and LED column stream of the POV text scroller.
interface pov_text_scroller_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic          clear;
  logic          wr_en;
  logic [6:0]    wr_code;
  logic          col_en;
  logic          rev;
  logic [7:0]    col_out;
  logic          frame_start;
  logic [LW-1:0] buf_len;
  logic          overflow;

  modport master (
    output clear, wr_en, wr_code, col_en, rev,
    input  col_out, frame_start, buf_len, overflow
  );

  modport slave (
    input  clear, wr_en, wr_code, col_en, rev,
    output col_out, frame_start, buf_len, overflow
  );
endinterface

// File: rtl/pov_text_scroller.sv
// Persistence-of-vision scroller: runtime-loadable character buffer streamed as
// 8-bit glyph columns, one per column strobe, with a blank gap between frames.
module pov_text_scroller #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned GAP   = 8
) (
  input logic clk,
  input logic rst_n,
  pov_text_scroller_if.slave bus
);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_GAP} state_t;

  // Glyph ROM: 8 columns per glyph, column 0 in the top byte
  function automatic logic [7:0] char_rom(input logic [6:0] code, input logic [2:0] col);
    logic [63:0] g;
    case (code)
      7'h10:   g = 64'h003E615149453E00;  // '0'
      7'h11:   g = 64'h0000427F40000000;  // '1'
      7'h21:   g = 64'h007C121111127C00;  // 'A'
      7'h22:   g = 64'h007F494949493600;  // 'B'
      default: g = 64'h0000000000000000;
    endcase
    return g[{~col, 3'b000} +: 8];
  endfunction

  logic [6:0]    buf_q [DEPTH];
  logic [LW-1:0] len_q;
  logic          ovf_q;
  state_t        state_q, state_nxt;
  logic [AW-1:0] ci_q, ci_nxt;
  logic [2:0]    cc_q, cc_nxt;
  logic [7:0]    gc_q, gc_nxt;
  logic          rev_q, rev_nxt;
  logic          fresh_q, fresh_nxt;
  logic [7:0]    col_q, col_nxt;
  logic          fs_q, fs_nxt;

  // Cursor for the current strobe: a frame start reloads it from rev/buf_len
  logic          start_c, scan_c, rev_c, last_col_c, last_chr_c;
  logic [AW-1:0] ci_c, len_m1_c;
  logic [2:0]    cc_c;

  assign len_m1_c   = AW'(len_q - LW'(1));
  assign start_c    = bus.col_en && (len_q != '0) &&
                      ((state_q == ST_IDLE) || ((state_q == ST_SCAN) && fresh_q));
  assign scan_c     = start_c || ((state_q == ST_SCAN) && !fresh_q);
  assign rev_c      = start_c ? bus.rev : rev_q;
  assign ci_c       = start_c ? (bus.rev ? len_m1_c : '0) : ci_q;
  assign cc_c       = start_c ? (bus.rev ? 3'd7 : 3'd0) : cc_q;
  assign last_col_c = (cc_c == (rev_c ? 3'd0 : 3'd7));
  // Forward mode compares against the live length so late appends still show
  assign last_chr_c = rev_c ? (ci_c == '0) : (ci_c == len_m1_c);

  // Character buffer, length and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.wr_en) begin
      if (len_q == LW'(DEPTH)) begin
        ovf_q <= 1'b1;
      end else begin
        buf_q[AW'(len_q)] <= bus.wr_code;
        len_q             <= len_q + LW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ci_q    <= '0;
      cc_q    <= '0;
      gc_q    <= '0;
      rev_q   <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ci_q    <= ci_nxt;
      cc_q    <= cc_nxt;
      gc_q    <= gc_nxt;
      rev_q   <= rev_nxt;
      fresh_q <= fresh_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    ci_nxt    = ci_q;
    cc_nxt    = cc_q;
    gc_nxt    = gc_q;
    rev_nxt   = rev_q;
    fresh_nxt = fresh_q;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
      fresh_nxt = 1'b0;
    end else if (bus.col_en) begin
      if (scan_c) begin
        state_nxt = ST_SCAN;
        rev_nxt   = rev_c;
        fresh_nxt = 1'b0;
        if (last_col_c && last_chr_c) begin
          state_nxt = ST_GAP;
          gc_nxt    = '0;
        end else if (last_col_c) begin
          ci_nxt = rev_c ? ci_c - AW'(1) : ci_c + AW'(1);
          cc_nxt = rev_c ? 3'd7 : 3'd0;
        end else begin
          ci_nxt = ci_c;
          cc_nxt = rev_c ? cc_c - 3'd1 : cc_c + 3'd1;
        end
      end else if (state_q == ST_GAP) begin
        if (gc_q == 8'(GAP - 1)) begin
          state_nxt = (len_q != '0) ? ST_SCAN : ST_IDLE;
          fresh_nxt = (len_q != '0);
        end else begin
          gc_nxt = gc_q + 8'd1;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    col_nxt = col_q;
    fs_nxt  = 1'b0;
    if (bus.clear) begin
      col_nxt = '0;
    end else if (bus.col_en) begin
      col_nxt = scan_c ? char_rom(buf_q[ci_c], cc_c) : 8'h00;
      fs_nxt  = start_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      col_q <= col_nxt;
      fs_q  <= fs_nxt;
    end
  end

  assign bus.col_out     = col_q;
  assign bus.frame_start = fs_q;
  assign bus.buf_len     = len_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_pov_text_scroller.sv
// Self-checking bench for pov_text_scroller: table-driven frames plus hand-written
// sequences for overflow, clear and asynchronous reset.
module tb_pov_text_scroller;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned GAP   = 8;

  typedef struct {
    logic       en;
    logic [7:0] col;
    logic       fs;
  } vec_t;
  typedef logic [6:0] code_q_t[$];
  typedef vec_t vec_q_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb_q[$];

  logic [7:0] glyph_0 [8] = '{8'h00, 8'h3E, 8'h61, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00};
  logic [7:0] glyph_a [8] = '{8'h00, 8'h7C, 8'h12, 8'h11, 8'h11, 8'h12, 8'h7C, 8'h00};

  always #5 clk = ~clk;

  pov_text_scroller_if #(.DEPTH(DEPTH)) bus_if ();
  pov_text_scroller #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  function automatic logic [7:0] glyph(input logic [6:0] code, input int col);
    case (code)
      7'h10:   return glyph_0[col];
      7'h21:   return glyph_a[col];
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive the strobe, queue its expectation, compare after the edge
  task automatic step(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    bus_if.col_en = v.en;
    bus_if.wr_en  = 1'b0;
    bus_if.clear  = 1'b0;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check({name, ".col"}, 32'(bus_if.col_out), 32'(e.col));
      check({name, ".fs"}, 32'(bus_if.frame_start), 32'(e.fs));
    end
  endtask

  task automatic write(input logic [6:0] code);
    @(negedge clk);
    bus_if.col_en  = 1'b0;
    bus_if.clear   = 1'b0;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_code = code;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus_if.col_en = 1'b0;
    bus_if.wr_en  = 1'b0;
    bus_if.clear  = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
  endtask

  // Expected strobe sequence of one whole frame: glyph columns then GAP blanks
  function automatic vec_q_t build_frame(input code_q_t codes, input bit rv);
    vec_q_t f;
    vec_t   v;
    int     n = codes.size();
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 8; c++) begin
        v.en  = 1'b1;
        v.col = glyph(codes[rv ? n - 1 - k : k], rv ? 7 - c : c);
        v.fs  = (k == 0) && (c == 0);
        f.push_back(v);
      end
    end
    for (int g = 0; g < int'(GAP); g++) begin
      v.en = 1'b1; v.col = 8'h00; v.fs = 1'b0;
      f.push_back(v);
    end
    return f;
  endfunction

  task automatic run_frames(input code_q_t codes, input bit rv, input int nstrobes,
                            input string name);
    vec_q_t vecs;
    vecs = build_frame(codes, rv);
    bus_if.rev = rv;
    for (int s = 0; s < nstrobes; s++) step(vecs[s % vecs.size()], name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    code_q_t codes;
    vec_q_t  vecs;
    vec_t    v;

    bus_if.clear = 1'b0; bus_if.wr_en = 1'b0; bus_if.wr_code = '0;
    bus_if.col_en = 1'b0; bus_if.rev = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.col_out", 32'(bus_if.col_out), 32'h00);
    check("reset.frame_start", 32'(bus_if.frame_start), 32'h0);
    check("reset.buf_len", 32'(bus_if.buf_len), 32'h0);
    check("reset.overflow", 32'(bus_if.overflow), 32'h0);

    // Empty buffer: strobes stay blank in IDLE
    v.en = 1'b1; v.col = 8'h00; v.fs = 1'b0;
    step(v, "idle_empty0");
    step(v, "idle_empty1");

    // Single 'A', forward
    write(7'h21);
    check("single.buf_len", 32'(bus_if.buf_len), 32'd1);
    codes = '{7'h21};
    run_frames(codes, 1'b0, 8, "single_a");

    // "0A" forward, 34 strobes: second frame_start on strobe 25
    do_clear();
    write(7'h10);
    write(7'h21);
    codes = '{7'h10, 7'h21};
    run_frames(codes, 1'b0, 34, "fwd_0a");

    // "0A" reverse, one frame plus restart
    do_clear();
    write(7'h10);
    write(7'h21);
    run_frames(codes, 1'b1, 26, "rev_0a");

    // Append mid-frame and strobe-less hold
    do_clear();
    write(7'h21);
    bus_if.rev = 1'b0;
    codes = '{7'h21, 7'h10};
    vecs = build_frame(codes, 1'b0);
    for (int s = 0; s < 3; s++) step(vecs[s], "append_pre");
    v.en = 1'b0; v.col = vecs[2].col; v.fs = 1'b0;
    step(v, "hold");
    write(7'h10);
    for (int s = 3; s < vecs.size() + 2; s++) step(vecs[s % vecs.size()], "append_post");

    // Overflow and clear
    do_clear();
    for (int i = 0; i < int'(DEPTH); i++) write(7'(i));
    check("full.buf_len", 32'(bus_if.buf_len), 32'(DEPTH));
    check("full.overflow", 32'(bus_if.overflow), 32'h0);
    write(7'h21);
    check("ovf.buf_len", 32'(bus_if.buf_len), 32'(DEPTH));
    check("ovf.overflow", 32'(bus_if.overflow), 32'h1);
    do_clear();
    check("clr.buf_len", 32'(bus_if.buf_len), 32'h0);
    check("clr.overflow", 32'(bus_if.overflow), 32'h0);
    v.en = 1'b1; v.col = 8'h00; v.fs = 1'b0;
    step(v, "clr_idle0");
    step(v, "clr_idle1");

    // clear and wr_en together: clear wins
    write(7'h21);
    check("pre_cw.buf_len", 32'(bus_if.buf_len), 32'd1);
    @(negedge clk);
    bus_if.col_en = 1'b0; bus_if.clear = 1'b1; bus_if.wr_en = 1'b1; bus_if.wr_code = 7'h21;
    @(negedge clk);
    bus_if.clear = 1'b0; bus_if.wr_en = 1'b0;
    check("clr_wr.buf_len", 32'(bus_if.buf_len), 32'h0);

    // clear mid-frame forces blank output
    write(7'h21);
    codes = '{7'h21};
    vecs = build_frame(codes, 1'b0);
    step(vecs[0], "midclr_pre0");
    step(vecs[1], "midclr_pre1");
    do_clear();
    check("midclr.col_out", 32'(bus_if.col_out), 32'h00);
    check("midclr.frame_start", 32'(bus_if.frame_start), 32'h0);
    v.en = 1'b1; v.col = 8'h00; v.fs = 1'b0;
    step(v, "midclr_idle");

    // Asynchronous reset mid-SCAN with col_en held high
    do_clear();
    write(7'h21);
    write(7'h21);
    codes = '{7'h21, 7'h21};
    vecs = build_frame(codes, 1'b0);
    for (int s = 0; s < 3; s++) step(vecs[s], "prerst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.col_out", 32'(bus_if.col_out), 32'h00);
    check("async_rst.frame_start", 32'(bus_if.frame_start), 32'h0);
    check("async_rst.buf_len", 32'(bus_if.buf_len), 32'h0);
    check("async_rst.overflow", 32'(bus_if.overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v.en = 1'b1; v.col = 8'h00; v.fs = 1'b0;
    for (int s = 0; s < 3; s++) step(v, "postrst_idle");
    write(7'h21);
    codes = '{7'h21};
    run_frames(codes, 1'b0, 4, "postrst_a");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
